alu_issue_stage: RTL and testbench

Pipeline register that sits directly upstream of the 32-bit ALU. It accepts decoded instructions from the decode stage through a valid/ready handshake and selects the X and Y operands (register, immediate or shift amount). It resolves data hazards by forwarding from the EX/MEM and MEM/WB results, and drives the ALU's `S`, `X` and `Y` inputs from a registered instruction slot. It supports downstream stall and pipeline flush.

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_fwd_mux.sv | 21 ++
 rtl/alu_issue_stage.sv | 157 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, operand payload and forwarding-priority function for the ALU issue stage.
package alu_pkg;

  localparam int unsigned ALU_XLEN = 32;
  localparam int unsigned ALU_OPW  = 4;
  localparam int unsigned REG_W    = 5;

  localparam logic [ALU_OPW-1:0] ALU_SLL     = 4'd0;
  localparam logic [ALU_OPW-1:0] ALU_SRA     = 4'd1;
  localparam logic [ALU_OPW-1:0] ALU_SRL     = 4'd2;
  localparam logic [ALU_OPW-1:0] ALU_MUL     = 4'd3;
  localparam logic [ALU_OPW-1:0] ALU_DIV     = 4'd4;
  localparam logic [ALU_OPW-1:0] ALU_ADD     = 4'd5;
  localparam logic [ALU_OPW-1:0] ALU_SUB     = 4'd6;
  localparam logic [ALU_OPW-1:0] ALU_AND     = 4'd7;
  localparam logic [ALU_OPW-1:0] ALU_OR      = 4'd8;
  localparam logic [ALU_OPW-1:0] ALU_XOR     = 4'd9;
  localparam logic [ALU_OPW-1:0] ALU_NOR     = 4'd10;
  localparam logic [ALU_OPW-1:0] ALU_SLT     = 4'd11;
  localparam logic [ALU_OPW-1:0] ALU_SLTU    = 4'd12;
  localparam logic [ALU_OPW-1:0] ALU_OP_LAST = 4'd12;

  // One ALU operand: value plus the register tag it may be refreshed from.
  typedef struct packed {
    logic [ALU_XLEN-1:0] value;
    logic [REG_W-1:0]    tag;
    logic                fwd_en;
  } operand_t;

  // Forwarded operand value; EX/MEM wins over MEM/WB, r0 and constants never forward.
  function automatic logic [ALU_XLEN-1:0] fwd_value(
    input operand_t            opnd,
    input logic                exm_we,
    input logic [REG_W-1:0]    exm_rd,
    input logic [ALU_XLEN-1:0] exm_res,
    input logic                wb_we,
    input logic [REG_W-1:0]    wb_rd,
    input logic [ALU_XLEN-1:0] wb_res
  );
    logic [ALU_XLEN-1:0] res;
    res = opnd.value;
    if (opnd.fwd_en && (opnd.tag != '0)) begin
      if (exm_we && (exm_rd == opnd.tag)) begin
        res = exm_res;
      end else if (wb_we && (wb_rd == opnd.tag)) begin
        res = wb_res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// Forwarding comparator/mux for one held operand.
// Ports: opnd (held operand), EX/MEM and MEM/WB write-back sources, value_c (forwarded value).
module alu_fwd_mux
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  operand_t         opnd,
  input  logic             exm_reg_write,
  input  logic [4:0]       exm_rd_num,
  input  logic [XLEN-1:0]  exm_result,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd_num,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  value_c
);

  assign value_c = XLEN'(fwd_value(opnd, exm_reg_write, exm_rd_num, ALU_XLEN'(exm_result),
                                   wb_reg_write, wb_rd_num, ALU_XLEN'(wb_data)));

endmodule

// File: rtl/alu_issue_stage.sv
// Issue register in front of the ALU: valid/ready capture, operand select, forwarding,
// stall-time operand refresh and flush.
// Ports: decode-side in_* handshake and fields; exm_*/wb_* forwarding sources; flush;
// out_ready/out_valid handshake; alu_s/alu_x/alu_y ALU drive; out_rd_num, out_reg_write,
// out_illegal. alu_x/alu_y are combinational from the held slot; the rest are flops.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [4:0]      in_rs_num,
  input  logic [4:0]      in_rt_num,
  input  logic [4:0]      in_rd_num,
  input  logic [XLEN-1:0] in_rs_data,
  input  logic [XLEN-1:0] in_rt_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [4:0]      in_shamt,
  input  logic            in_use_shamt,
  input  logic            in_reg_write,
  input  logic            exm_reg_write,
  input  logic [4:0]      exm_rd_num,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd_num,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [OPW-1:0]  alu_s,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  output logic [4:0]      out_rd_num,
  output logic            out_reg_write,
  output logic            out_illegal
);

  logic           valid_q, valid_d;
  logic [OPW-1:0] op_q, op_d;
  logic [4:0]     rd_q, rd_d;
  logic           we_q, we_d;
  logic           illegal_q, illegal_d;
  operand_t       x_q, x_d, y_q, y_d;
  operand_t       x_new_c, y_new_c;
  logic [XLEN-1:0] x_fwd_c, y_fwd_c;
  logic           capture_c;

  assign in_ready  = !valid_q || out_ready;
  assign capture_c = in_valid && in_ready && !flush;

  // Forwarded view of the held operands: drives the ALU and the stall refresh.
  alu_fwd_mux #(.XLEN(XLEN)) u_fwd_x (
    .opnd(x_q), .exm_reg_write(exm_reg_write), .exm_rd_num(exm_rd_num),
    .exm_result(exm_result), .wb_reg_write(wb_reg_write), .wb_rd_num(wb_rd_num),
    .wb_data(wb_data), .value_c(x_fwd_c)
  );

  alu_fwd_mux #(.XLEN(XLEN)) u_fwd_y (
    .opnd(y_q), .exm_reg_write(exm_reg_write), .exm_rd_num(exm_rd_num),
    .exm_result(exm_result), .wb_reg_write(wb_reg_write), .wb_rd_num(wb_rd_num),
    .wb_data(wb_data), .value_c(y_fwd_c)
  );

  // Incoming operand selection; shift form moves rt to X and puts shamt in Y.
  always_comb begin
    x_new_c = '0;
    y_new_c = '0;
    if (in_use_shamt) begin
      x_new_c.value  = ALU_XLEN'(in_rt_data);
      x_new_c.tag    = in_rt_num;
      x_new_c.fwd_en = 1'b1;
      y_new_c.value  = ALU_XLEN'(in_shamt);
    end else begin
      x_new_c.value  = ALU_XLEN'(in_rs_data);
      x_new_c.tag    = in_rs_num;
      x_new_c.fwd_en = 1'b1;
      if (in_use_imm) begin
        y_new_c.value = ALU_XLEN'(in_imm);
      end else begin
        y_new_c.value  = ALU_XLEN'(in_rt_data);
        y_new_c.tag    = in_rt_num;
        y_new_c.fwd_en = 1'b1;
      end
    end
  end

  // Slot next-state: capture, stall refresh, drain and flush.
  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    rd_d      = rd_q;
    we_d      = we_q;
    x_d       = x_q;
    y_d       = y_q;

    if (capture_c) begin
      op_d = in_op;
      rd_d = in_rd_num;
      we_d = in_reg_write && (in_rd_num != 5'd0);
      x_d  = x_new_c;
      y_d  = y_new_c;
      x_d.value = fwd_value(x_new_c, exm_reg_write, exm_rd_num, ALU_XLEN'(exm_result),
                            wb_reg_write, wb_rd_num, ALU_XLEN'(wb_data));
      y_d.value = fwd_value(y_new_c, exm_reg_write, exm_rd_num, ALU_XLEN'(exm_result),
                            wb_reg_write, wb_rd_num, ALU_XLEN'(wb_data));
    end else if (valid_q && !out_ready) begin
      // Latch whatever is being forwarded now so a retiring producer is not lost.
      x_d.value = ALU_XLEN'(x_fwd_c);
      y_d.value = ALU_XLEN'(y_fwd_c);
    end

    if (flush) begin
      valid_d = 1'b0;
    end else if (capture_c) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    illegal_d = valid_d && (op_d > OPW'(ALU_OP_LAST));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      op_q      <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      illegal_q <= illegal_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign out_valid     = valid_q;
  assign alu_s         = op_q;
  assign alu_x         = x_fwd_c;
  assign alu_y         = y_fwd_c;
  assign out_rd_num    = rd_q;
  assign out_reg_write = we_q;
  assign out_illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs_num, in_rt_num, in_rd_num;
  logic [31:0] in_rs_data, in_rt_data, in_imm;
  logic        in_use_imm, in_use_shamt, in_reg_write;
  logic [4:0]  in_shamt;
  logic        exm_reg_write, wb_reg_write;
  logic [4:0]  exm_rd_num, wb_rd_num;
  logic [31:0] exm_result, wb_data;
  logic        flush, out_ready, out_valid;
  logic [3:0]  alu_s;
  logic [31:0] alu_x, alu_y;
  logic [4:0]  out_rd_num;
  logic        out_reg_write, out_illegal;

  int vectors = 0;
  int miscompares = 0;

  alu_issue_stage #(.XLEN(32), .OPW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs_num(in_rs_num), .in_rt_num(in_rt_num), .in_rd_num(in_rd_num),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_shamt(in_shamt), .in_use_shamt(in_use_shamt),
    .in_reg_write(in_reg_write), .exm_reg_write(exm_reg_write), .exm_rd_num(exm_rd_num),
    .exm_result(exm_result), .wb_reg_write(wb_reg_write), .wb_rd_num(wb_rd_num),
    .wb_data(wb_data), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .alu_s(alu_s), .alu_x(alu_x), .alu_y(alu_y), .out_rd_num(out_rd_num),
    .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_op = 0; in_rs_num = 0; in_rt_num = 0; in_rd_num = 0;
    in_rs_data = 0; in_rt_data = 0; in_imm = 0; in_use_imm = 0; in_shamt = 0;
    in_use_shamt = 0; in_reg_write = 0; exm_reg_write = 0; exm_rd_num = 0;
    exm_result = 0; wb_reg_write = 0; wb_rd_num = 0; wb_data = 0; flush = 0;
    out_ready = 1;
  endtask

  task automatic put_rr(input logic [3:0] op, input logic [4:0] rs, input logic [31:0] rsd,
                        input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd);
    in_valid = 1; in_op = op; in_rs_num = rs; in_rs_data = rsd; in_rt_num = rt;
    in_rt_data = rtd; in_rd_num = rd; in_reg_write = 1; in_use_imm = 0; in_use_shamt = 0;
  endtask

  // Reference forward: tag 0 or constant -> raw; EX/MEM first, then MEM/WB.
  function automatic logic [31:0] ref_fwd(input logic [31:0] v, input logic [4:0] t,
                                          input logic en);
    if (t == 0 || !en) return v;
    if (exm_reg_write && exm_rd_num == t) return exm_result;
    if (wb_reg_write && wb_rd_num == t) return wb_data;
    return v;
  endfunction

  task automatic test_reset();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    vectors++; if ({alu_s, alu_x, alu_y} !== 68'h0) begin miscompares++; $display("FAIL reset_alu got %h %h %h exp 0", alu_s, alu_x, alu_y); end
    vectors++; if ({out_rd_num, out_reg_write, out_illegal} !== 7'h0) begin miscompares++; $display("FAIL reset_misc got %h %b %b exp 0", out_rd_num, out_reg_write, out_illegal); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add();
    put_rr(4'd5, 5'd1, 32'h5, 5'd2, 32'h7, 5'd3);
    tick(); idle(); #1;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid got %b exp 1", out_valid); end
    vectors++; if (alu_s !== 4'd5) begin miscompares++; $display("FAIL add_s got %0d exp 5", alu_s); end
    vectors++; if (alu_x !== 32'h5 || alu_y !== 32'h7) begin miscompares++; $display("FAIL add_xy got %h %h exp 5 7", alu_x, alu_y); end
    vectors++; if (out_rd_num !== 5'd3 || out_reg_write !== 1'b1) begin miscompares++; $display("FAIL add_rd got %0d %b exp 3 1", out_rd_num, out_reg_write); end
    // rd 0 never writes
    put_rr(4'd6, 5'd1, 32'h1, 5'd2, 32'h2, 5'd0);
    tick(); idle(); #1;
    vectors++; if (out_reg_write !== 1'b0) begin miscompares++; $display("FAIL rd0_we got %b exp 0", out_reg_write); end
  endtask

  task automatic test_shift_fwd();
    put_rr(4'd0, 5'd9, 32'hDEAD, 5'd3, 32'h1, 5'd4);
    in_use_shamt = 1; in_shamt = 5'd4;
    tick(); idle(); #1;
    vectors++; if (alu_x !== 32'h1 || alu_y !== 32'h4) begin miscompares++; $display("FAIL sll_xy got %h %h exp 1 4", alu_x, alu_y); end
    put_rr(4'd0, 5'd9, 32'hDEAD, 5'd3, 32'h1, 5'd4);
    in_use_shamt = 1; in_shamt = 5'd4;
    exm_reg_write = 1; exm_rd_num = 5'd3; exm_result = 32'h80;
    tick(); idle(); #1;
    vectors++; if (alu_x !== 32'h80 || alu_y !== 32'h4) begin miscompares++; $display("FAIL sll_fwd got %h %h exp 80 4", alu_x, alu_y); end
  endtask

  task automatic test_priority();
    put_rr(4'd5, 5'd4, 32'h11, 5'd7, 32'h0, 5'd2);
    in_use_imm = 1; in_imm = 32'h22;
    exm_reg_write = 1; exm_rd_num = 5'd4; exm_result = 32'hAA;
    wb_reg_write = 1; wb_rd_num = 5'd4; wb_data = 32'hBB;
    tick(); idle(); #1;
    vectors++; if (alu_x !== 32'hAA || alu_y !== 32'h22) begin miscompares++; $display("FAIL prio_exm got %h %h exp aa 22", alu_x, alu_y); end
    put_rr(4'd5, 5'd0, 32'h33, 5'd0, 32'h44, 5'd2);
    exm_reg_write = 1; exm_rd_num = 5'd0; exm_result = 32'hAA;
    wb_reg_write = 1; wb_rd_num = 5'd0; wb_data = 32'hBB;
    tick(); in_valid = 0; #1;
    vectors++; if (alu_x !== 32'h33 || alu_y !== 32'h44) begin miscompares++; $display("FAIL prio_r0 got %h %h exp 33 44", alu_x, alu_y); end
    idle();
  endtask

  task automatic test_stall();
    put_rr(4'd6, 5'd5, 32'h10, 5'd6, 32'h20, 5'd7);
    tick(); idle(); out_ready = 0;
    exm_reg_write = 1; exm_rd_num = 5'd6; exm_result = 32'h1234;
    #1;
    vectors++; if (alu_y !== 32'h1234) begin miscompares++; $display("FAIL stall_c1 got %h exp 1234", alu_y); end
    tick(); exm_reg_write = 0; exm_result = 0; #1;
    vectors++; if (alu_y !== 32'h1234 || out_valid !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_c2 got %h %b %b exp 1234 1 0", alu_y, out_valid, in_ready); end
    tick();
    put_rr(4'd8, 5'd1, 32'h99, 5'd2, 32'h98, 5'd1); out_ready = 0; #1;
    vectors++; if (alu_y !== 32'h1234 || alu_s !== 4'd6) begin miscompares++; $display("FAIL stall_c3 got %h %0d exp 1234 6", alu_y, alu_s); end
    tick(); idle(); #1;
    vectors++; if (alu_y !== 32'h1234 || alu_x !== 32'h10 || out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_emit got %h %h %b exp 1234 10 1", alu_y, alu_x, out_valid); end
    tick(); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    put_rr(4'd7, 5'd1, 32'h1, 5'd2, 32'h2, 5'd8);
    tick(); idle(); out_ready = 0; tick();
    put_rr(4'd9, 5'd3, 32'h3, 5'd4, 32'h4, 5'd9); out_ready = 0; flush = 1; #1;
    vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL flush_pre got %b %b exp 0 1", in_ready, out_valid); end
    tick(); idle(); #1;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_post got %b %b exp 0 1", out_valid, in_ready); end
    put_rr(4'd8, 5'd1, 32'h55, 5'd2, 32'h66, 5'd3);
    tick(); idle(); #1;
    vectors++; if (out_valid !== 1'b1 || alu_s !== 4'd8 || alu_x !== 32'h55) begin miscompares++; $display("FAIL flush_next got %b %0d %h exp 1 8 55", out_valid, alu_s, alu_x); end
  endtask

  task automatic test_illegal_reset();
    put_rr(4'd14, 5'd1, 32'h77, 5'd2, 32'h88, 5'd5);
    tick(); idle(); out_ready = 0; #1;
    vectors++; if (out_illegal !== 1'b1 || alu_s !== 4'd14) begin miscompares++; $display("FAIL illegal got %b %0d exp 1 14", out_illegal, alu_s); end
    tick();
    rst = 1; #1;
    vectors++; if ({out_valid, alu_s, alu_x, alu_y, out_rd_num, out_reg_write, out_illegal} !== 76'h0) begin miscompares++; $display("FAIL async_rst got %b %h %h %h %h %b %b exp 0", out_valid, alu_s, alu_x, alu_y, out_rd_num, out_reg_write, out_illegal); end
    rst = 0; tick(); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_rst got %b exp 0", out_valid); end
    put_rr(4'd5, 5'd1, 32'h3, 5'd2, 32'h4, 5'd6);
    tick(); idle(); #1;
    vectors++; if (out_valid !== 1'b1 || alu_s !== 4'd5 || alu_x !== 32'h3) begin miscompares++; $display("FAIL post_rst_cap got %b %0d %h exp 1 5 3", out_valid, alu_s, alu_x); end
  endtask

  task automatic test_random();
    logic        m_valid, m_we, exp_ready, cap;
    logic [3:0]  m_op;
    logic [4:0]  m_rd, m_xt, m_yt;
    logic [31:0] m_xv, m_yv, exp_x, exp_y;
    logic        m_xe, m_ye;
    logic [12:0] exp_ctl;
    rst = 1; #1; rst = 0;
    m_valid = 0; m_we = 0; m_op = 0; m_rd = 0;
    m_xv = 0; m_xt = 0; m_xe = 0; m_yv = 0; m_yt = 0; m_ye = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_op = 4'($urandom_range(0, 15));
      in_rs_num = 5'($urandom_range(0, 7)); in_rt_num = 5'($urandom_range(0, 7));
      in_rd_num = 5'($urandom_range(0, 7));
      in_rs_data = $urandom(); in_rt_data = $urandom(); in_imm = $urandom();
      in_use_imm = 1'($urandom_range(0, 1)); in_use_shamt = ($urandom_range(0, 3) == 0);
      in_shamt = 5'($urandom()); in_reg_write = 1'($urandom_range(0, 1));
      exm_reg_write = 1'($urandom_range(0, 1)); exm_rd_num = 5'($urandom_range(0, 7));
      exm_result = $urandom();
      wb_reg_write = 1'($urandom_range(0, 1)); wb_rd_num = 5'($urandom_range(0, 7));
      wb_data = $urandom();
      flush = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      exp_ready = !m_valid || out_ready;
      exp_ctl = {m_valid, exp_ready, (m_valid && (m_op >= 4'd13)), m_we, m_op, m_rd};
      exp_x = ref_fwd(m_xv, m_xt, m_xe);
      exp_y = ref_fwd(m_yv, m_yt, m_ye);
      vectors++;
      if ({out_valid, in_ready, out_illegal, out_reg_write, alu_s, out_rd_num} !== exp_ctl) begin
        miscompares++;
        $display("FAIL rand_ctl cycle %0d got %h exp %h", i,
                 {out_valid, in_ready, out_illegal, out_reg_write, alu_s, out_rd_num}, exp_ctl);
      end
      vectors++;
      if (alu_x !== exp_x || alu_y !== exp_y) begin
        miscompares++;
        $display("FAIL rand_xy cycle %0d got %h %h exp %h %h", i, alu_x, alu_y, exp_x, exp_y);
      end
      cap = in_valid && exp_ready && !flush;
      if (cap) begin
        m_op = in_op; m_rd = in_rd_num; m_we = in_reg_write && (in_rd_num != 0);
        if (in_use_shamt) begin
          m_xv = ref_fwd(in_rt_data, in_rt_num, 1'b1); m_xt = in_rt_num; m_xe = 1;
          m_yv = {27'b0, in_shamt}; m_yt = 0; m_ye = 0;
        end else begin
          m_xv = ref_fwd(in_rs_data, in_rs_num, 1'b1); m_xt = in_rs_num; m_xe = 1;
          if (in_use_imm) begin
            m_yv = in_imm; m_yt = 0; m_ye = 0;
          end else begin
            m_yv = ref_fwd(in_rt_data, in_rt_num, 1'b1); m_yt = in_rt_num; m_ye = 1;
          end
        end
      end else if (m_valid && !out_ready) begin
        m_xv = exp_x; m_yv = exp_y;
      end
      if (flush) m_valid = 0;
      else if (cap) m_valid = 1;
      else if (out_ready) m_valid = 0;
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 0;
    tick();
    test_add();
    test_shift_fwd();
    test_priority();
    test_stall();
    test_flush();
    test_illegal_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
